recog_sequencer: RTL and testbench

Top-level sequencer for the isolated-word recognition core. After a start request it steps the speech buffer frame by frame through the FFT and feature-extraction engines. It then runs the template matcher over every vocabulary word and reports the best-matching word index with a one-cycle acknowledge. An overflow flag marks the result as unreliable.

---
 rtl/recog_sequencer.sv | 168 ++++++++++++++++
 tb/tb_recog_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/recog_sequencer.sv
// Top-level sequencer for the isolated-word recognizer: walks the utterance through
// FFT and feature extraction frame by frame, then scores every vocabulary template.
module recog_sequencer #(
  parameter int NUM_FRAMES  = 40,
  parameter int FRAME_SHIFT = 128,
  parameter int ADDR_W      = 14,
  parameter int NUM_WORDS   = 50,
  parameter int DIST_W      = 24,
  parameter int TIMEOUT     = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              fft_start,
  input  logic              fft_finish,
  output logic [ADDR_W-1:0] frame_base,
  output logic [5:0]        frame_idx,
  output logic              feat_start,
  input  logic              feat_done,
  output logic              match_start,
  output logic [5:0]        match_word,
  input  logic              match_done,
  input  logic [DIST_W-1:0] match_dist,
  output logic              busy,
  output logic              result_ack,
  output logic [5:0]        result,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, FFT_RUN, FEAT_RUN, MATCH_RUN, DONE} state_t;

  localparam int                WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [5:0]        LAST_FRAME = 6'(NUM_FRAMES - 1);
  localparam logic [5:0]        LAST_WORD  = 6'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] SHIFT      = ADDR_W'(FRAME_SHIFT);
  localparam logic [DIST_W-1:0] DIST_MAX   = '1;
  localparam logic [5:0]        NO_WORD    = 6'h3F;

  state_t            state;
  logic              start_d;
  logic [DIST_W-1:0] best_dist;
  logic [5:0]        best_idx;
  logic              any_match;
  logic [WD_W-1:0]   wd;

  logic              accept;
  logic              engine_done;
  logic              better;
  logic [DIST_W-1:0] best_dist_nx;
  logic [5:0]        best_idx_nx;

  assign accept = start & ~start_d & (state == IDLE);
  assign busy   = (state != IDLE);

  // The best-so-far values including the distance arriving this cycle, so the
  // final word's score is already folded in when the result is registered.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    engine_done = 1'b0;
    case (state)
      FFT_RUN:   engine_done = fft_finish;
      FEAT_RUN:  engine_done = feat_done;
      MATCH_RUN: engine_done = match_done;
      default:   engine_done = 1'b0;
    endcase
    better       = (state == MATCH_RUN) && match_done && (match_dist < best_dist);
    best_dist_nx = better ? match_dist : best_dist;
    best_idx_nx  = better ? match_word : best_idx;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      fft_start   <= 1'b0;
      feat_start  <= 1'b0;
      match_start <= 1'b0;
      result_ack  <= 1'b0;
      frame_base  <= '0;
      frame_idx   <= '0;
      match_word  <= '0;
      result      <= '0;
      overflow    <= 1'b0;
      best_dist   <= DIST_MAX;
      best_idx    <= '0;
      any_match   <= 1'b0;
      wd          <= '0;
    end else begin
      start_d     <= start;
      fft_start   <= 1'b0;
      feat_start  <= 1'b0;
      match_start <= 1'b0;
      result_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            frame_idx  <= '0;
            frame_base <= '0;
            match_word <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            best_dist  <= DIST_MAX;
            best_idx   <= '0;
            any_match  <= 1'b0;
            wd         <= '0;
            fft_start  <= 1'b1;
            state      <= FFT_RUN;
          end
        end

        FFT_RUN, FEAT_RUN, MATCH_RUN: begin
          if (engine_done) begin
            // The watchdog bounds each individual engine wait, so it restarts per handshake.
            wd <= '0;
            case (state)
              FFT_RUN: begin
                feat_start <= 1'b1;
                state      <= FEAT_RUN;
              end
              FEAT_RUN: begin
                if (frame_idx == LAST_FRAME) begin
                  match_word  <= '0;
                  match_start <= 1'b1;
                  state       <= MATCH_RUN;
                end else begin
                  frame_idx  <= frame_idx + 1'b1;
                  frame_base <= frame_base + SHIFT;
                  fft_start  <= 1'b1;
                  state      <= FFT_RUN;
                end
              end
              default: begin
                best_dist <= best_dist_nx;
                best_idx  <= best_idx_nx;
                any_match <= 1'b1;
                if (match_word == LAST_WORD) begin
                  result     <= best_idx_nx;
                  overflow   <= overflow | (best_dist_nx == DIST_MAX);
                  result_ack <= 1'b1;
                  state      <= DONE;
                end else begin
                  match_word  <= match_word + 1'b1;
                  match_start <= 1'b1;
                end
              end
            endcase
          end else if (wd == WD_MAX) begin
            wd         <= '0;
            overflow   <= 1'b1;
            result     <= any_match ? best_idx : NO_WORD;
            result_ack <= 1'b1;
            state      <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        // result and result_ack were registered on entry; DONE lasts exactly one cycle.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recog_sequencer.sv
// Self-checking bench for recog_sequencer: random-latency engine models, random
// template distances scored by a min-search reference, plus directed corner runs.
module tb_recog_sequencer;

  localparam int NF = 3;
  localparam int NW = 4;
  localparam int FS = 128;
  localparam int AW = 14;
  localparam int DW = 24;
  localparam int TO = 20;
  localparam logic [DW-1:0] DMAX = '1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          fft_start, feat_start, match_start;
  logic          fft_finish = 1'b0;
  logic          feat_done = 1'b0;
  logic          match_done = 1'b0;
  logic [DW-1:0] match_dist = '0;
  logic [AW-1:0] frame_base;
  logic [5:0]    frame_idx, match_word, result;
  logic          busy, result_ack, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  recog_sequencer #(
    .NUM_FRAMES(NF), .FRAME_SHIFT(FS), .ADDR_W(AW),
    .NUM_WORDS(NW), .DIST_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .fft_start(fft_start), .fft_finish(fft_finish),
    .frame_base(frame_base), .frame_idx(frame_idx),
    .feat_start(feat_start), .feat_done(feat_done),
    .match_start(match_start), .match_word(match_word),
    .match_done(match_done), .match_dist(match_dist),
    .busy(busy), .result_ack(result_ack), .result(result), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine models and stimulus controls.
  logic [DW-1:0] dist_tab [NW];
  bit            fft_en    = 1'b1;
  bit            glitch_en = 1'b0;

  initial begin
    int fc, ec, mc;
    logic [5:0] w;
    fc = 0; ec = 0; mc = 0; w = '0;
    forever begin
      @(negedge clk);
      fft_finish = 1'b0;
      feat_done  = 1'b0;
      match_done = 1'b0;
      if (!reset) begin
        fc = 0; ec = 0; mc = 0;
      end else begin
        if (fc > 0) begin fc--; if (fc == 0) fft_finish = 1'b1; end
        if (ec > 0) begin ec--; if (ec == 0) feat_done = 1'b1; end
        if (mc > 0) begin
          mc--;
          if (mc == 0) begin match_done = 1'b1; match_dist = dist_tab[w]; end
        end
        if (fft_start && fft_en) fc = $urandom_range(2, 8);
        if (fft_start && glitch_en) feat_done = 1'b1;
        if (feat_start) ec = $urandom_range(1, 8);
        if (match_start) begin w = match_word; mc = $urandom_range(1, 8); end
      end
    end
  end

  // Passive monitor: pulse counts and per-pulse address/word traces.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_fft = 0, n_feat = 0, n_match = 0, n_ack = 0, n_multi = 0;
  int last_fft_cyc = 0;
  logic [AW-1:0] fb_q [$];
  logic [5:0]    mw_q [$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (fft_start)   begin n_fft++; fb_q.push_back(frame_base); last_fft_cyc = cyc; end
      if (feat_start)  n_feat++;
      if (match_start) begin n_match++; mw_q.push_back(match_word); end
      if (result_ack)  n_ack++;
      if (int'(fft_start) + int'(feat_start) + int'(match_start) > 1) n_multi++;
    end
  end

  // Reference: smallest distance wins, first occurrence on ties; all-ones best is unreliable.
  function automatic void model(output logic [5:0] idx, output logic ovf);
    logic [DW-1:0] mn;
    mn = DMAX;
    foreach (dist_tab[i]) if (dist_tab[i] < mn) mn = dist_tab[i];
    idx = '0;
    for (int i = NW - 1; i >= 0; i--) if (dist_tab[i] == mn) idx = 6'(i);
    ovf = (mn == DMAX);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, ".ctl_zero"},
          32'({fft_start, feat_start, match_start, busy, result_ack, overflow,
               result, match_word, frame_idx}), 32'd0);
    check({tag, ".base_zero"}, 32'(frame_base), 32'd0);
  endtask

  // mode 0: normal, 1: start re-pulse + stray feat_done, 2: FFT never finishes
  task automatic run_one(input string tag, input int mode);
    int f0, e0, m0, a0, x0, q0, w0, budget, t_ack;
    int exp_fft, exp_feat, exp_match;
    logic [5:0] exp_res;
    logic       exp_ovf;
    f0 = n_fft; e0 = n_feat; m0 = n_match; a0 = n_ack; x0 = n_multi;
    q0 = fb_q.size(); w0 = mw_q.size();
    if (mode == 2) begin
      exp_res = 6'h3F; exp_ovf = 1'b1; exp_fft = 1; exp_feat = 0; exp_match = 0;
    end else begin
      model(exp_res, exp_ovf); exp_fft = NF; exp_feat = NF; exp_match = NW;
    end
    glitch_en = (mode == 1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check({tag, ".fft_start_lat"}, 32'(fft_start), 32'd1);
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    repeat (9) @(negedge clk);
    start = 1'b0;

    if (mode == 1) begin
      budget = 0;
      while (!feat_start && budget < 500) begin @(negedge clk); budget++; end
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
    end

    budget = 0;
    while (!result_ack && budget < 2000) begin @(negedge clk); budget++; end
    t_ack = cyc;
    check({tag, ".ack_seen"}, 32'(result_ack), 32'd1);
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".busy_in_done"}, 32'(busy), 32'd1);
    if (mode == 2) check({tag, ".timeout_lat"}, 32'(t_ack - last_fft_cyc), 32'(TO + 1));

    @(negedge clk);
    glitch_en = 1'b0;
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    check({tag, ".ack_one_cycle"}, 32'(result_ack), 32'd0);
    check({tag, ".result_held"}, 32'(result), 32'(exp_res));

    check({tag, ".n_fft"}, 32'(n_fft - f0), 32'(exp_fft));
    check({tag, ".n_feat"}, 32'(n_feat - e0), 32'(exp_feat));
    check({tag, ".n_match"}, 32'(n_match - m0), 32'(exp_match));
    check({tag, ".n_ack"}, 32'(n_ack - a0), 32'd1);
    check({tag, ".exclusive"}, 32'(n_multi - x0), 32'd0);
    if (fb_q.size() == q0 + exp_fft)
      for (int i = 0; i < exp_fft; i++)
        check({tag, ".frame_base"}, 32'(fb_q[q0+i]), 32'(AW'(i * FS)));
    if (mw_q.size() == w0 + exp_match)
      for (int i = 0; i < exp_match; i++)
        check({tag, ".match_word"}, 32'(mw_q[w0+i]), 32'(i));
  endtask

  initial begin
    int a0, budget;
    #2 reset = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int r = 0; r < 4; r++) begin
      foreach (dist_tab[i])
        dist_tab[i] = (r == 3) ? DW'($urandom) : DW'($urandom_range(0, 20));
      run_one("rand", 0);
    end

    dist_tab[0] = 900; dist_tab[1] = 300; dist_tab[2] = 300; dist_tab[3] = 700;
    run_one("tie", 0);

    foreach (dist_tab[i]) dist_tab[i] = DMAX;
    run_one("all_max", 0);

    fft_en = 1'b0;
    run_one("timeout", 2);
    fft_en = 1'b1;

    foreach (dist_tab[i]) dist_tab[i] = DW'($urandom_range(0, 1000));
    run_one("ignore", 1);

    // Reset in the middle of template matching.
    @(negedge clk);
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (!match_start && budget < 500) begin @(negedge clk); budget++; end
    check("midreset.reached_match", 32'(match_start), 32'd1);
    @(negedge clk);
    a0 = n_ack;
    #2 reset = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset.no_ack", 32'(n_ack - a0), 32'd0);
    check("midreset.idle", 32'(busy), 32'd0);

    foreach (dist_tab[i]) dist_tab[i] = DW'($urandom_range(0, 1000));
    run_one("after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
